// File: rtl/demux4_stream_max.sv
// Registered 1-to-4 stream demultiplexer: one valid/ready input steered to channels F/E/C/B
// by {S1,S2} or an internal round-robin pointer, plus a running unsigned maximum tracker.
module demux4_stream_max #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         S1,
   input  logic         S2,
   input  logic         mode,
   input  logic         clr_max,
   output logic [W-1:0] F,
   output logic [W-1:0] E,
   output logic [W-1:0] C,
   output logic [W-1:0] B,
   output logic         vld_F,
   output logic         vld_E,
   output logic         vld_C,
   output logic         vld_B,
   input  logic         rdy_F,
   input  logic         rdy_E,
   input  logic         rdy_C,
   input  logic         rdy_B,
   output logic [W-1:0] max_out,
   output logic [1:0]   max_ch,
   output logic         max_valid
);

   localparam int NCH = 4;

   // Channel codes match the 4:1 selector encoding.
   typedef enum logic [1:0] {
      CH_F = 2'b00,
      CH_E = 2'b01,
      CH_C = 2'b10,
      CH_B = 2'b11
   } ch_e;

   logic [NCH-1:0] rdy_vec;
   ch_e            sel;
   logic           accept;

   logic [W-1:0]   data_q [NCH];
   logic [W-1:0]   data_d [NCH];
   logic [NCH-1:0] vld_q;
   logic [NCH-1:0] vld_d;
   logic [1:0]     rr_q;
   logic [1:0]     rr_d;

   logic [W-1:0]   max_q;
   logic [W-1:0]   max_d;
   ch_e            max_ch_q;
   ch_e            max_ch_d;
   logic           max_valid_q;
   logic           max_valid_d;

   assign rdy_vec = {rdy_B, rdy_C, rdy_E, rdy_F};

   // A mode change redirects steering in the same cycle; rr_q itself is untouched by mode.
   always_comb begin
      sel = mode ? ch_e'(rr_q) : ch_e'({S1, S2});
   end

   // A full channel that drains this cycle can take the next word.
   assign in_ready = ~vld_q[sel] | rdy_vec[sel];
   assign accept   = in_valid & in_ready;

   // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         data_d[i] = data_q[i];
         vld_d[i]  = vld_q[i] & ~rdy_vec[i];
      end
      if (accept) begin
         data_d[sel] = din;
         vld_d[sel]  = 1'b1;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (accept && mode) begin
         rr_d = rr_q + 2'd1;
      end
   end

   // Strict compare keeps the earlier word on ties; clr_max with an accept restarts from din.
   always_comb begin
      max_d       = max_q;
      max_ch_d    = max_ch_q;
      max_valid_d = max_valid_q;
      if (accept && (clr_max || !max_valid_q || (din > max_q))) begin
         max_d       = din;
         max_ch_d    = sel;
         max_valid_d = 1'b1;
      end else if (clr_max) begin
         max_d       = '0;
         max_ch_d    = CH_F;
         max_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the channel data array is reset because its contents are directly visible on F/E/C/B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= '0;
         end
         vld_q <= '0;
         rr_q  <= 2'd0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= data_d[i];
         end
         vld_q <= vld_d;
         rr_q  <= rr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q       <= '0;
         max_ch_q    <= CH_F;
         max_valid_q <= 1'b0;
      end else begin
         max_q       <= max_d;
         max_ch_q    <= max_ch_d;
         max_valid_q <= max_valid_d;
      end
   end

   assign F         = data_q[CH_F];
   assign E         = data_q[CH_E];
   assign C         = data_q[CH_C];
   assign B         = data_q[CH_B];
   assign vld_F     = vld_q[CH_F];
   assign vld_E     = vld_q[CH_E];
   assign vld_C     = vld_q[CH_C];
   assign vld_B     = vld_q[CH_B];
   assign max_out   = max_q;
   assign max_ch    = max_ch_q;
   assign max_valid = max_valid_q;

endmodule

// File: doc/demux4_stream_max.md
Name: demux4_stream_max

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart of the team's 4:1 bus selector.
- Takes a stream of W-bit words on one valid/ready input and steers each word to one of four output channels, F, E, C and B.
- Steering uses the same select encoding as the selector: {S1,S2} = 00 goes to F, 01 to E, 10 to C, 11 to B.
- Alternatively, steering uses an internal round-robin pointer.
- The block also tracks the running unsigned maximum of all accepted words, and which channel received it, for the max datapath.

Parameters:
- W, 4, data word width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  input data word.
- in_valid  input  1  din is valid.
- in_ready  output  1  block accepts din this cycle (combinational).
- S1  input  1  select MSB (mode=0 only).
- S2  input  1  select LSB (mode=0 only).
- mode  input  1  0 = select-driven; 1 = round-robin.
- clr_max  input  1  synchronous clear of the max tracker.
- F, E, C, B  output  W each  channel data registers (codes 00, 01, 10, 11).
- vld_F, vld_E, vld_C, vld_B  output  1 each  channel holds an undelivered word.
- rdy_F, rdy_E, rdy_C, rdy_B  input  1 each  downstream consumer takes the channel word.
- max_out  output  W  largest word accepted since reset or clear.
- max_ch  output  2  channel code that received max_out.
- max_valid  output  1  max_out is meaningful.

Behaviour:
- Reset (rst=1, asynchronous):
  - F, E, C, B = 0; all vld_* = 0.
  - rr_ptr = 0.
  - max_out = 0, max_ch = 00, max_valid = 0.
  - in_ready = 1 once rst is released.
  - Any held words are discarded.
- Channel select:
  - sel = {S1,S2} when mode = 0.
  - sel = rr_ptr (2-bit) when mode = 1.
  - Combinational, sampled each cycle.
- Ready: in_ready = ~vld[sel] | rdy[sel]. A full channel that drains in the same cycle can still accept a word.
- Accept:
  - An accept occurs when in_valid & in_ready.
  - At the next clock edge, channel[sel] <= din and vld[sel] <= 1.
  - Latency is 1 cycle from accept to vld visible.
  - Other channels are unaffected.
- Drain:
  - vld_x & rdy_x clears vld_x at the next edge.
  - If the same channel is refilled in that cycle, vld stays 1 and the data is replaced.
  - The data register holds its value after drain; it is not zeroed.
- No accept when in_valid=0, or when sel points at a full channel whose rdy is 0.
  - The input stalls: no rr_ptr advance, no max update.
- Round-robin:
  - rr_ptr increments mod 4 only on an accept while mode=1; wrap is 3 -> 0.
  - rr_ptr holds when mode=0 and is never reset by a mode change.
  - A mode change takes effect in the cycle it is applied.
- Max tracker, on accept:
  - If max_valid=0 or din > max_out (unsigned): max_out <= din, max_ch <= sel, max_valid <= 1.
  - Ties keep the earlier word and its channel.
- clr_max:
  - clr_max=1 without an accept: max_out <= 0, max_ch <= 00, max_valid <= 0.
  - clr_max together with an accept: the accepted word becomes the new max and max_valid = 1.
- Independence: all four channels drain independently in the same cycle, and a simultaneous accept and drain on different channels both complete.
- Outputs are all registered except in_ready.

Test Plan:
- Reset, then mode=0 with {S1,S2} = 00, 01, 10, 11, din = 3, 9, 5, 12 on consecutive cycles, all rdy=0. Required:
  - F=3, E=9, C=5, B=12, all vld=1.
  - max_out=12, max_ch=11.
  - Then in_ready=0 for any sel.
- Backpressure and same-cycle refill: F full, rdy_F=0, sel=00, din=7. Required:
  - in_ready=0 and F holds 3.
  - Raise rdy_F in the same cycle: accept occurs, F=7, vld_F stays 1.
- Round-robin: mode=1, rr_ptr=0, all rdy=1, din = 1..6 each cycle. Required:
  - Words land on F, E, C, B, F, E.
  - rr_ptr ends at 2, demonstrating the 3 -> 0 wrap.
- Ties and clear:
  - Accept 8 on E, then 8 on C: max_ch stays 01.
  - clr_max alone: max_valid=0, max_out=0.
  - clr_max together with an accept of 2 on B: max_out=2, max_ch=11, max_valid=1.
- Asynchronous reset mid-stream: assert rst between clock edges while channels are full. Required:
  - All vld_* and max_valid = 0 immediately.
  - rr_ptr = 0 and the first post-reset round-robin word goes to F.
